// File: rtl/tmr_vote_monitor.sv
// rtl/tmr_vote_monitor.sv - registered 2-of-3 majority voter with per-lane error tracking and health FSM
//
// Ports:
//   S_AXI_ACLK        clock, all logic on the rising edge
//   S_AXI_ARESET      synchronous active-high reset
//   in_valid          qualifies lane0..lane2 this cycle
//   lane0/1/2         redundant copies of the result word
//   clr               one-cycle clear of counters, failed mask and health FSM
//   voted_data        registered bitwise majority word
//   voted_valid       in_valid delayed by one cycle
//   lane_mismatch     lanes that differed from the majority in the last valid sample
//   lane_failed       sticky per-lane failure flags
//   err_cnt0/1/2      saturating per-lane mismatch totals
//   health            0=NOMINAL 1=SUSPECT 2=DEGRADED 3=FATAL
//   fatal             health == FATAL
module tmr_vote_monitor #(
    parameter int DATA_W      = 32,
    parameter int FAIL_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] lane0,
    input  logic [DATA_W-1:0] lane1,
    input  logic [DATA_W-1:0] lane2,
    input  logic              clr,
    output logic [DATA_W-1:0] voted_data,
    output logic              voted_valid,
    output logic [2:0]        lane_mismatch,
    output logic [2:0]        lane_failed,
    output logic [CNT_W-1:0]  err_cnt0,
    output logic [CNT_W-1:0]  err_cnt1,
    output logic [CNT_W-1:0]  err_cnt2,
    output logic [1:0]        health,
    output logic              fatal
);

    typedef enum logic [1:0] {
        NOMINAL  = 2'd0,
        SUSPECT  = 2'd1,
        DEGRADED = 2'd2,
        FATAL    = 2'd3
    } health_t;

    localparam logic [3:0]       THRESH  = 4'(FAIL_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    health_t           state_q, state_d;
    logic [DATA_W-1:0] maj;
    logic [2:0]        mm;
    logic              no_pair;
    logic              update;
    logic [DATA_W-1:0] lanes   [3];
    logic [3:0]        run_q   [3];
    logic [3:0]        run_d   [3];
    logic [CNT_W-1:0]  cnt_q   [3];
    logic [2:0]        failed_q;
    logic [2:0]        failed_d;
    logic [1:0]        n_failed;
    logic              all_runs_zero;

    assign lanes[0] = lane0;
    assign lanes[1] = lane1;
    assign lanes[2] = lane2;

    assign maj     = (lane0 & lane1) | (lane1 & lane2) | (lane0 & lane2);
    assign mm      = {lane2 != maj, lane1 != maj, lane0 != maj};
    assign no_pair = (lane0 != lane1) && (lane1 != lane2) && (lane0 != lane2);

    // clr takes precedence: a sample arriving with clr is voted but not tracked.
    assign update = in_valid && !clr;

    // Next run lengths and failure mask as they would be after this sample.
    always_comb begin
        failed_d      = failed_q;
        all_runs_zero = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_d[k] = 4'd0;
            if (mm[k]) begin
                run_d[k] = (run_q[k] >= THRESH) ? THRESH : run_q[k] + 4'd1;
            end
            if (run_d[k] == THRESH) begin
                failed_d[k] = 1'b1;
            end
            if (run_d[k] != 4'd0) begin
                all_runs_zero = 1'b0;
            end
        end
        n_failed = {1'b0, failed_d[0]} + {1'b0, failed_d[1]} + {1'b0, failed_d[2]};
    end

    // Health FSM next state; only valid, non-cleared samples move it.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = NOMINAL;
        end else if (in_valid) begin
            if (state_q == FATAL || no_pair || n_failed >= 2'd2) begin
                state_d = FATAL;
            end else if (state_q == DEGRADED || n_failed == 2'd1) begin
                state_d = DEGRADED;
            end else if (state_q == NOMINAL) begin
                if (|mm) begin
                    state_d = SUSPECT;
                end
            end else if (all_runs_zero) begin
                state_d = NOMINAL;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q <= NOMINAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            voted_data    <= '0;
            voted_valid   <= 1'b0;
            lane_mismatch <= 3'b000;
            failed_q      <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                run_q[k] <= 4'd0;
                cnt_q[k] <= '0;
            end
        end else begin
            voted_valid <= in_valid;
            if (in_valid) begin
                voted_data    <= maj;
                lane_mismatch <= mm;
            end
            if (clr) begin
                failed_q <= 3'b000;
                for (int k = 0; k < 3; k++) begin
                    run_q[k] <= 4'd0;
                    cnt_q[k] <= '0;
                end
            end else if (update) begin
                failed_q <= failed_d;
                for (int k = 0; k < 3; k++) begin
                    run_q[k] <= run_d[k];
                    if (mm[k] && cnt_q[k] != CNT_MAX) begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign lane_failed = failed_q;
    assign err_cnt0    = cnt_q[0];
    assign err_cnt1    = cnt_q[1];
    assign err_cnt2    = cnt_q[2];
    assign health      = state_q;
    assign fatal       = (state_q == FATAL);

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// tb/tb_tmr_vote_monitor.sv - table-driven self-checking bench for tmr_vote_monitor
module tb_tmr_vote_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] l0 = '0;
    logic [31:0] l1 = '0;
    logic [31:0] l2 = '0;

    logic [31:0] vd;
    logic        vv;
    logic [2:0]  mm;
    logic [2:0]  fl;
    logic [15:0] c0, c1, c2;
    logic [1:0]  h;
    logic        ft;

    logic [31:0] s_vd;
    logic        s_vv;
    logic [2:0]  s_mm;
    logic [2:0]  s_fl;
    logic [3:0]  s_c0, s_c1, s_c2;
    logic [1:0]  s_h;
    logic        s_ft;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmr_vote_monitor dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .in_valid(vld),
        .lane0(l0), .lane1(l1), .lane2(l2), .clr(clr),
        .voted_data(vd), .voted_valid(vv), .lane_mismatch(mm), .lane_failed(fl),
        .err_cnt0(c0), .err_cnt1(c1), .err_cnt2(c2), .health(h), .fatal(ft)
    );

    tmr_vote_monitor #(.DATA_W(32), .FAIL_THRESH(4), .CNT_W(4)) dut_s (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .in_valid(vld),
        .lane0(l0), .lane1(l1), .lane2(l2), .clr(clr),
        .voted_data(s_vd), .voted_valid(s_vv), .lane_mismatch(s_mm), .lane_failed(s_fl),
        .err_cnt0(s_c0), .err_cnt1(s_c1), .err_cnt2(s_c2), .health(s_h), .fatal(s_ft)
    );

    typedef struct {
        logic        rst, clr, vld;
        logic [31:0] l0, l1, l2;
        logic [31:0] vd;
        logic        vv;
        logic [2:0]  mm, fl;
        logic [15:0] c0, c1, c2;
        logic [1:0]  h;
    } vec_t;

    vec_t tbl[$];

    function void add(input logic r, input logic c, input logic v,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                      input logic [31:0] e_vd, input logic e_vv, input logic [2:0] e_mm,
                      input logic [2:0] e_fl, input logic [15:0] e_c0, input logic [15:0] e_c1,
                      input logic [15:0] e_c2, input logic [1:0] e_h);
        vec_t t;
        t.rst = r; t.clr = c; t.vld = v; t.l0 = a; t.l1 = b; t.l2 = d;
        t.vd = e_vd; t.vv = e_vv; t.mm = e_mm; t.fl = e_fl;
        t.c0 = e_c0; t.c1 = e_c1; t.c2 = e_c2; t.h = e_h;
        tbl.push_back(t);
    endfunction

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        rst = r; clr = c; vld = v; l0 = a; l1 = b; l2 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [94:0] act, exp;

        add(1,0,0, 32'h0, 32'h0, 32'h0,  32'h0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        add(1,0,0, 32'h0, 32'h0, 32'h0,  32'h0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        add(0,0,1, 32'hFF, 32'hFF, 32'hFF,  32'hFF, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        add(0,0,1, 32'h0, 32'hFFFF_FFFF, 32'h0,  32'h0, 1, 3'b010, 3'b000, 0, 1, 0, 1);
        add(0,0,0, 32'h0, 32'h0, 32'h0,  32'h0, 0, 3'b010, 3'b000, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            add(0,0,1, 32'h0, 32'h0, 32'h0,  32'h0, 1, 3'b000, 3'b000, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++)
            add(0,0,1, 32'h0, 32'h0, 32'h20,  32'h0, 1, 3'b100, (i == 4) ? 3'b100 : 3'b000,
                0, 1, 16'(i), (i == 4) ? 2'd2 : 2'd1);
        for (int i = 0; i < 10; i++)
            add(0,0,1, 32'h0, 32'h0, 32'h0,  32'h0, 1, 3'b000, 3'b100, 0, 1, 4, 2);
        add(0,0,1, 32'h1, 32'h2, 32'h4,  32'h0, 1, 3'b111, 3'b100, 1, 2, 5, 3);
        for (int i = 0; i < 2; i++)
            add(0,0,1, 32'h0, 32'h0, 32'h0,  32'h0, 1, 3'b000, 3'b100, 1, 2, 5, 3);
        add(0,1,0, 32'h0, 32'h0, 32'h0,  32'h0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            add(0,0,1, 32'h1, 32'h2, 32'h0,  32'h0, 1, 3'b011, (i == 4) ? 3'b011 : 3'b000,
                16'(i), 16'(i), 0, 3);
        add(1,0,1, 32'h33, 32'h33, 32'h77,  32'h0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        add(0,1,1, 32'hAA, 32'hAA, 32'hAB,  32'hAA, 1, 3'b100, 3'b000, 0, 0, 0, 0);
        add(0,0,1, 32'hAA, 32'hAA, 32'hAA,  32'hAA, 1, 3'b000, 3'b000, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].l0, tbl[i].l1, tbl[i].l2);
            act = {vd, vv, mm, fl, c0, c1, c2, h, ft};
            exp = {tbl[i].vd, tbl[i].vv, tbl[i].mm, tbl[i].fl, tbl[i].c0, tbl[i].c1,
                   tbl[i].c2, tbl[i].h, tbl[i].h == 2'd3};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d: got vd=%h vv=%b mm=%b fl=%b c=%h/%h/%h h=%0d f=%b expected vd=%h vv=%b mm=%b fl=%b c=%h/%h/%h h=%0d f=%b",
                         i, vd, vv, mm, fl, c0, c1, c2, h, ft,
                         exp[94:63], exp[62], exp[61:59], exp[58:56], exp[55:40], exp[39:24],
                         exp[23:8], exp[2:1], exp[0]);
            end
        end

        // Saturation: lane0 keeps mismatching well past the 4-bit counter range.
        step(0, 1, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 1, 32'h5, 32'h0, 32'h0);
            if (i == 3)  chk("health_suspect_run3", 32'(h), 32'd1);
            if (i == 14) chk("small_cnt_14", 32'(s_c0), 32'hE);
            if (i == 16) chk("cnt0_16", 32'(c0), 32'd16);
        end
        chk("small_cnt_sat", 32'(s_c0), 32'hF);
        chk("cnt0_20", 32'(c0), 32'd20);
        chk("failed_lane0", 32'(fl), 32'b001);
        chk("health_degraded", 32'(h), 32'd2);
        chk("small_health", 32'(s_h), 32'd2);
        chk("voted_sat", vd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Downstream consumer of the triplicated result words (result, result1, result2) produced by the redundant compute stage.
- Performs a registered bitwise 2-of-3 majority vote and flags which lanes disagree with the voted word.
- Tracks per-lane error counts and consecutive-mismatch runs, and runs a health FSM (NOMINAL/SUSPECT/DEGRADED/FATAL) that the AXI slave exposes to software for fault-tolerance reporting.

Parameters:
- DATA_W, 32, width of each redundant lane and of the voted output.
- FAIL_THRESH, 4, consecutive mismatching valid samples needed to mark a lane failed (legal range 1..15).
- CNT_W, 16, width of each per-lane saturating error counter.

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies the three lane inputs this cycle.
- lane0  in  DATA_W  redundant copy 0 (result).
- lane1  in  DATA_W  redundant copy 1 (result1).
- lane2  in  DATA_W  redundant copy 2 (result2).
- clr  in  1  single-cycle clear of counters, failed mask and FSM.
- voted_data  out  DATA_W  registered majority word.
- voted_valid  out  1  in_valid delayed by one cycle.
- lane_mismatch  out  3  bit k=1 if lane k differed from the majority in the last valid sample.
- lane_failed  out  3  sticky, bit k set when lane k reaches FAIL_THRESH.
- err_cnt0, err_cnt1, err_cnt2  out  CNT_W each  saturating mismatch totals per lane.
- health  out  2  0=NOMINAL, 1=SUSPECT, 2=DEGRADED, 3=FATAL.
- fatal  out  1  equals (health==3).

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, S_AXI_ACLK; reset S_AXI_ARESET is synchronous and active-high.
  - Reset drives all outputs to 0 (health = NOMINAL) and zeroes the internal run counters. Reset has priority over clr and in_valid.
  - Reset asserted mid-stream discards the in-flight sample, so voted_valid is 0 on the next cycle.
- Vote:
  - maj = (lane0&lane1)|(lane1&lane2)|(lane0&lane2), computed bitwise.
  - mm[k] = (lane_k != maj), full-word compare.
  - In the cycle after in_valid=1: voted_data=maj, voted_valid=1, lane_mismatch=mm.
  - When in_valid=0: voted_data and lane_mismatch hold their values; voted_valid=0.
  - Latency is exactly 1 cycle. Throughput is one sample per cycle with no backpressure.
- Counters (update only on in_valid=1):
  - err_cntk increments when mm[k]=1 and saturates at all-ones.
  - run_k increments when mm[k]=1 and resets to 0 when mm[k]=0. It saturates at FAIL_THRESH.
  - lane_failed[k] sets when run_k would reach FAIL_THRESH and stays set until clr or reset.
- no_pair: no two lanes are word-equal (lane0!=lane1, lane1!=lane2, lane0!=lane2).
- FSM (evaluated on in_valid=1 samples; otherwise holds):
  - NOMINAL -> SUSPECT if any mm=1 and no lane_failed is set.
  - SUSPECT -> NOMINAL when all run_k=0 after a sample.
  - SUSPECT or NOMINAL -> DEGRADED when exactly one lane_failed bit becomes set.
  - DEGRADED: stays DEGRADED. Further mismatches on the failed lane are counted but do not change state.
  - Any state -> FATAL on no_pair, or when two or more lane_failed bits are set. FATAL is sticky.
  - FATAL exits only via clr or reset.
  - Voting continues in every state. voted_data is still the bitwise majority in DEGRADED and FATAL.
- clr=1:
  - Next cycle: err_cnt*=0, run_k=0, lane_failed=0, health=NOMINAL.
  - If in_valid=1 in the same cycle, the vote is registered normally, but counters and FSM ignore that sample (clr wins).
- Simultaneous failures: if two lanes reach FAIL_THRESH in the same sample, go directly to FATAL, skipping DEGRADED.
- Width rules: counters use unsigned arithmetic. Run counters are 4 bits wide.

Test Plan:
- Reset then lanes=0x0000_00FF ×3, in_valid=1 for 1 cycle -> next cycle voted_data=0x0000_00FF, voted_valid=1, lane_mismatch=000, health=0, all err_cnt=0.
- lane1=0xFFFF_FFFF, lane0=lane2=0x0 for 1 sample, then 3 clean samples -> voted_data=0x0, lane_mismatch=010, err_cnt1=1, health 1 then back to 0 after the first clean sample.
- lane2 flipped bit 5 for 4 consecutive samples (FAIL_THRESH=4) -> lane_failed=100 after the 4th sample, health=2, err_cnt2=4. Remains 2 after 10 more clean samples.
- lane0=0x1, lane1=0x2, lane2=0x4 for one sample -> voted_data=0x0, lane_mismatch=111, health=3, fatal=1. Stays 3 on clean samples until clr=1, then health=0 and counters=0 on the next cycle.
- lane0 wrong for 4 samples, lane1 wrong for the same 4 samples -> both bits of lane_failed set on the same sample, health goes straight to 3. Separately, force err_cnt0 to 0xFFFF with continued mismatches -> it holds at 0xFFFF.
- Mid-stream: S_AXI_ARESET=1 while in_valid=1 -> next cycle voted_valid=0, all outputs 0. Also clr=1 with a mismatching in_valid sample -> vote registered, err_cnt unchanged at 0, health=0.
